// File: rtl/input_conditioner.sv
// input_conditioner: per-channel synchronizer, debounce filter and edge pulses.
// Ports: sys_dom_i (.clk only), async_rst_n, data_i, bypass_i -> sync_o, level_o, rise_o, fall_o.
package sys_structs;
    typedef struct packed {
        logic clk;
        logic clk_en;
        logic sync_rst;
    } clk_domain;
endpackage

module input_conditioner
    import sys_structs::*;
#(
    parameter int CHANNELS = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_CYCLES = 4,
    parameter logic [CHANNELS-1:0] RESET_VALUE = '0
) (
    input  clk_domain           sys_dom_i,
    input  logic                async_rst_n,
    input  logic [CHANNELS-1:0] data_i,
    input  logic [CHANNELS-1:0] bypass_i,
    output logic [CHANNELS-1:0] sync_o,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o
);

    localparam int CNT_WIDTH =
        (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'(FILTER_CYCLES - 1);

    logic clk;
    logic unused_dom;

    assign clk = sys_dom_i.clk;
    // Clock enable and sync reset of the domain bundle play no role here.
    assign unused_dom = sys_dom_i.clk_en ^ sys_dom_i.sync_rst;

    logic [CHANNELS-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                stage_q[k] <= RESET_VALUE;
            end
        end else begin
            stage_q[0] <= data_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign sync_o = stage_q[SYNC_STAGES-1];

    logic [CHANNELS-1:0] level_q;
    logic [CHANNELS-1:0] level_d;
    logic [CHANNELS-1:0] rise_q;
    logic [CHANNELS-1:0] fall_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [CNT_WIDTH-1:0] cnt_q;
        logic [CNT_WIDTH-1:0] cnt_d;
        logic                 lvl_d;

        // Any agreeing sample drops the count, so only an unbroken
        // run of differing samples can move the level.
        always_comb begin
            lvl_d = level_q[c];
            cnt_d = '0;
            if (sync_o[c] != level_q[c]) begin
                if (bypass_i[c] || (cnt_q == CNT_LAST)) begin
                    lvl_d = sync_o[c];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge async_rst_n) begin
            if (!async_rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign level_d[c] = lvl_d;
    end

    // Pulses are registered alongside level so they line up with it.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            level_q <= RESET_VALUE;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
            fall_q  <= ~level_d & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed checks of reset, filtering, bounce, bypass.
// Two instances: RESET_VALUE=4'b0101 for reset checks, defaults for the rest.
module tb_input_conditioner;
    import sys_structs::*;

    logic      clk = 1'b0;
    logic      rst_n = 1'b1;
    clk_domain dom;

    always #5 clk = ~clk;
    assign dom = {clk, 1'b1, 1'b0};

    logic [3:0] data_r, bypass_r, sync_r, level_r, rise_r, fall_r;
    logic [3:0] data_d, bypass_d, sync_d, level_d, rise_d, fall_d;

    input_conditioner #(.RESET_VALUE(4'b0101)) u_rst (
        .sys_dom_i(dom), .async_rst_n(rst_n),
        .data_i(data_r), .bypass_i(bypass_r),
        .sync_o(sync_r), .level_o(level_r),
        .rise_o(rise_r), .fall_o(fall_r)
    );

    input_conditioner u_dut (
        .sys_dom_i(dom), .async_rst_n(rst_n),
        .data_i(data_d), .bypass_i(bypass_d),
        .sync_o(sync_d), .level_o(level_d),
        .rise_o(rise_d), .fall_o(fall_d)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       pat [8];
        logic [3:0] hist [16];
        logic       v;

        data_r = 4'b0101;
        bypass_r = 4'b0000;
        data_d = 4'b0000;
        bypass_d = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_sync_r", sync_r, 4'b0101);
        chk("rst_level_r", level_r, 4'b0101);
        chk("rst_sync_d", sync_d, 4'b0000);
        chk("rst_level_d", level_d, 4'b0000);
        repeat (2) step();
        chk("rst_hold_sync_r", sync_r, 4'b0101);
        chk("rst_pulse_r", rise_r | fall_r, 4'b0000);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("post_rst_level_r", level_r, 4'b0101);
            chk("post_rst_pulse_r", rise_r | fall_r, 4'b0000);
            chk("post_rst_pulse_d", rise_d | fall_d, 4'b0000);
        end

        // Clean rising edge on channel 0.
        data_d[0] = 1'b1;
        step();
        chk("ce_sync_e0", {3'b0, sync_d[0]}, 4'd0);
        step();
        chk("ce_sync_e1", {3'b0, sync_d[0]}, 4'd1);
        repeat (3) begin
            step();
            chk("ce_level_early", {3'b0, level_d[0]}, 4'd0);
        end
        step();
        chk("ce_level_e5", {3'b0, level_d[0]}, 4'd1);
        chk("ce_rise_e5", rise_d, 4'b0001);
        step();
        chk("ce_rise_e6", rise_d, 4'b0000);

        // 3-cycle pulse on channel 1 must vanish.
        data_d[1] = 1'b1;
        repeat (3) step();
        data_d[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("gl3_level", {3'b0, level_d[1]}, 4'd0);
            chk("gl3_pulse", {2'b0, rise_d[1], fall_d[1]}, 4'd0);
        end

        // 4-cycle pulse: rise at E5, fall at E9.
        data_d[1] = 1'b1;
        repeat (4) step();
        data_d[1] = 1'b0;
        for (int i = 4; i <= 10; i++) begin
            step();
            chk("gl4_rise", {3'b0, rise_d[1]}, {3'b0, i == 5});
            chk("gl4_fall", {3'b0, fall_d[1]}, {3'b0, i == 9});
            chk("gl4_level", {3'b0, level_d[1]},
                {3'b0, (i >= 5) && (i < 9)});
        end

        // Bounce on channel 2: the 0 sample restarts the count.
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            data_d[2] = pat[i];
            step();
            chk("bn_level_early", {3'b0, level_d[2]}, 4'd0);
        end
        step();
        chk("bn_level_e8", {3'b0, level_d[2]}, 4'd0);
        chk("bn_rise_e8", {3'b0, rise_d[2]}, 4'd0);
        step();
        chk("bn_level_e9", {3'b0, level_d[2]}, 4'd1);
        chk("bn_rise_e9", rise_d, 4'b0100);
        step();
        chk("bn_rise_e10", rise_d, 4'b0000);

        // Bypass on channel 3 with a 2-cycle toggle.
        bypass_d[3] = 1'b1;
        for (int i = 0; i < 16; i++) hist[i] = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            v = ((i / 2) % 2) == 0;
            data_d[3] = v;
            hist[i+3] = {3'b0, v};
            step();
            chk("bp_sync", {3'b0, sync_d[3]}, hist[i+2]);
            chk("bp_level", {3'b0, level_d[3]}, hist[i+1]);
            chk("bp_rise", {3'b0, rise_d[3]}, hist[i+1] & ~hist[i]);
            chk("bp_fall", {3'b0, fall_d[3]}, ~hist[i+1] & hist[i]
                & 4'b0001);
        end
        bypass_d[3] = 1'b0;
        data_d[3] = 1'b0;
        repeat (4) step();
        chk("bp_settle", {3'b0, level_d[3]}, 4'd0);

        // Bypass asserted mid-count forces the update a cycle early.
        data_d[3] = 1'b1;
        repeat (4) step();
        chk("bpm_level_e3", {3'b0, level_d[3]}, 4'd0);
        bypass_d[3] = 1'b1;
        step();
        chk("bpm_level_e4", {3'b0, level_d[3]}, 4'd1);
        chk("bpm_rise_e4", rise_d, 4'b1000);
        bypass_d[3] = 1'b0;
        step();
        chk("bpm_rise_e5", rise_d, 4'b0000);

        // Async reset with channel 1 at cnt=2.
        data_d[1] = 1'b1;
        repeat (4) step();
        chk("ar_level_pre", level_d, 4'b1101);
        rst_n = 1'b0;
        #1;
        chk("ar_level", level_d, 4'b0000);
        chk("ar_sync", sync_d, 4'b0000);
        chk("ar_pulse", rise_d | fall_d, 4'b0000);
        chk("ar_level_r", level_r, 4'b0101);
        data_d = 4'b0000;
        repeat (2) step();
        chk("ar_hold_pulse", rise_d | fall_d, 4'b0000);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("ar_post_level", level_d, 4'b0000);
            chk("ar_post_pulse", rise_d | fall_d, 4'b0000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Multi-channel input conditioner for asynchronous or bouncing signals entering a clock domain. Each channel passes through a parametrised-depth synchronizer, then a per-channel stability (debounce) filter with run-time bypass. A registered rise/fall pulse is produced on every filtered transition. This block replaces a bare register chain on slow external inputs (buttons, straps, status lines) wherever reset values and glitch rejection matter.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent channels; must be ≥1.
- `SYNC_STAGES`, 2: synchronizer flops per channel; must be ≥2.
- `FILTER_CYCLES`, 4: consecutive cycles a synchronized value must differ from `level_o` before `level_o` takes it.
  - Must be ≥1.
  - 1 means no filtering beyond one register.
- `RESET_VALUE`, `'0`, width `CHANNELS`: reset value of every synchronizer stage and of `level_o`.
- `CNT_WIDTH`, derived: `max(1, $clog2(FILTER_CYCLES))`. Not user-set.

Ports:
- `sys_dom_i` input `sys_structs::clk_domain`: only `.clk` is used. `.clk_en` and `.sync_rst` are ignored.
- `async_rst_n` input, 1 bit: asynchronous, active-low reset. Assertion takes effect immediately; deassertion is expected to be synchronized externally.
- `data_i` input, `CHANNELS` bits: raw asynchronous inputs.
- `bypass_i` input, `CHANNELS` bits: per-channel filter bypass, synchronous to `clk`. When 1, the channel behaves as if `FILTER_CYCLES`=1.
- `sync_o` output, `CHANNELS` bits: last synchronizer stage (unfiltered).
- `level_o` output, `CHANNELS` bits: filtered level.
- `rise_o` output, `CHANNELS` bits: one-cycle pulse when `level_o` goes 0→1.
- `fall_o` output, `CHANNELS` bits: one-cycle pulse when `level_o` goes 1→0.

## Operation
- Per channel, synchronizer: `stage[0] <= data_i[c]`, then `stage[k] <= stage[k-1]`. `sync_o[c] = stage[SYNC_STAGES-1]`.
- Per channel, filter with counter `cnt` (CNT_WIDTH bits) and register `level`:
  - `sync == level`: `cnt <= 0`, `level` holds.
  - `sync != level` and (`bypass_i[c]` or `cnt == FILTER_CYCLES-1`): `level <= sync`, `cnt <= 0`.
  - `sync != level` otherwise: `cnt <= cnt+1`.
- Bounce rule: any cycle with `sync == level` clears `cnt`. Only an uninterrupted run of `FILTER_CYCLES` differing cycles propagates.
- Edge pulses:
  - `rise_o[c] <= level_next & ~level`.
  - `fall_o[c] <= ~level_next & level`.
  - Pulses are registered, so they are high in exactly the cycle in which `level_o` first shows the new value.
- Bypass behaviour:
  - Asserting `bypass_i[c]` mid-count clears `cnt` on the next edge.
  - `level` follows `sync` on that edge.
  - Deasserting `bypass_i` restarts filtering with `cnt`=0.
- `rise_o` and `fall_o` are never both high on the same channel. Channels are fully independent.
- Counter overflow cannot occur, because `cnt` never exceeds `FILTER_CYCLES-1`.

## Timing
- Reset values, all asynchronous on `async_rst_n`=0:
  - All synchronizer stages = `RESET_VALUE`.
  - `level_o` = `RESET_VALUE`.
  - `cnt` = 0.
  - `rise_o` = `fall_o` = 0.
- No spurious edges after reset release, provided `data_i` equals `RESET_VALUE`.
- Latency, counting E0 as the first clock edge that captures a new stable `data_i`:
  - `sync_o` updates at E0+`SYNC_STAGES`-1.
  - `level_o` and the edge pulse update at E0+`SYNC_STAGES`-1+`FILTER_CYCLES` (use 1 for bypassed channels).
- Defaults give `sync_o` at E0+1 and `level_o` at E0+5.
- Reset asserted mid-count: the count is discarded, with no pulse emitted. After release, filtering restarts from `RESET_VALUE`.
- A `data_i` pulse shorter than `FILTER_CYCLES` cycles (as seen at `sync_o`) never reaches `level_o`.
- Throughput: one filtered transition per channel per `FILTER_CYCLES` cycles at most.

## Test plan
- Reset: hold `async_rst_n`=0 with `RESET_VALUE`=4'b0101 and `data_i`=4'b0101, then release and run 20 cycles. Required: `level_o`=4'b0101 throughout, `rise_o`/`fall_o`=0, and `sync_o` equal to `RESET_VALUE` during reset.
- Clean edge, defaults: `data_i[0]` goes 0→1 before E0. Required: `sync_o[0]`=1 at E0+1, `level_o[0]`=1 and `rise_o[0]`=1 at E0+5, `rise_o[0]`=0 at E0+6.
- Glitch rejection: a 3-cycle high pulse on `data_i[1]` with `FILTER_CYCLES`=4. Required: `level_o[1]` stays 0 with no pulse. A 4-cycle pulse instead produces a rise then a fall, 4 cycles apart.
- Bounce reset: `data_i[2]` pattern 1,1,1,0,1,1,1,1. Required: `cnt` clears on the 0 sample, and `level_o[2]` rises only after the final 4 consecutive 1s at `sync_o`.
- Bypass: `bypass_i[3]`=1 while `data_i[3]` toggles every 2 cycles. Required: `level_o[3]` mirrors `sync_o[3]` delayed by 1 cycle, with alternating `rise_o`/`fall_o` pulses. Asserting `bypass_i` mid-count forces the update on the next edge.
- Async reset mid-count: assert `async_rst_n`=0 at `cnt`=2. Required: outputs return to reset values immediately, with no pulse during or after reset.
